// File: rtl/iob_reg_arb.sv
// -----------------------------------------------------------------------------
// iob_reg_arb
//
// Round-robin write arbiter in front of one shared enabled, synchronously
// clearable register. Each requester presents a request bit and a data word.
// One requester is granted at a time. Its word is loaded into the register,
// and a one-cycle acknowledge is returned to it.
//
// Optional feature macro: IOB_REG_ARB_LOCK_EN
//   When defined, this adds the lock_i port and the LOCKED state. An owner that
//   holds its lock bit keeps exclusive access for back-to-back writes.
//   When undefined, ACK always returns to IDLE.
//
// Parameters:
//   N_REQ   - number of requesters (2..16)
//   DATA_W  - register width
//   RST_VAL - register value on reset and on clear
//   ID_W    - (local) width of owner_o
//
// Ports:
//   clk_i     in   1             clock
//   cke_i     in   1             clock enable; low freezes all state
//   arst_n_i  in   1             asynchronous active-low reset
//   clr_i     in   1             synchronous clear of the register to RST_VAL
//   req_i     in   N_REQ         write request, one bit per requester
//   data_i    in   N_REQ*DATA_W  write data; requester k uses [k*DATA_W +: DATA_W]
//   lock_i    in   N_REQ         grant lock request (lock build only)
//   ack_o     out  N_REQ         one-cycle write acknowledge, one-hot or zero
//   data_o    out  DATA_W        register contents
//   owner_o   out  ID_W          index of the last granted requester
//   upd_o     out  1             one-cycle pulse: data_o changed by a granted write
//
// All outputs come straight from flops. No combinational path exists from
// the inputs to the outputs.
// -----------------------------------------------------------------------------
module iob_reg_arb #(
    parameter  int                N_REQ   = 4,
    parameter  int                DATA_W  = 21,
    parameter  logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
    localparam int                ID_W    = $clog2(N_REQ)
) (
    input  logic                      clk_i,
    input  logic                      cke_i,
    input  logic                      arst_n_i,
    input  logic                      clr_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
`ifdef IOB_REG_ARB_LOCK_EN
    input  logic [N_REQ-1:0]          lock_i,
`endif
    output logic [N_REQ-1:0]          ack_o,
    output logic [DATA_W-1:0]         data_o,
    output logic [ID_W-1:0]           owner_o,
    output logic                      upd_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1
`ifdef IOB_REG_ARB_LOCK_EN
        , ST_LOCKED = 2'd2
`endif
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;        // last granted index; the search starts at ptr+1
    logic [ID_W-1:0]     owner;
    logic [N_REQ-1:0]    ack;
    logic                upd;
    logic [DATA_W-1:0]   data_q;

    logic [DATA_W-1:0]   slice [N_REQ];
    logic                win_valid;
    logic [ID_W-1:0]     win_idx;
    logic                grant;
    logic [ID_W-1:0]     grant_idx;
    logic                reg_en;
    logic [DATA_W-1:0]   reg_d;

    // Split the flat data bus into one word per requester.
    for (genvar k = 0; k < N_REQ; k++) begin : g_slice
        assign slice[k] = data_i[k*DATA_W +: DATA_W];
    end

    // Ring position 'offset' steps after 'base', modulo N_REQ.
    // This keeps the index legal when N_REQ is not a power of two.
    function automatic logic [ID_W-1:0] ring_idx(input logic [ID_W-1:0] base,
                                                 input int              offset);
        int sum;
        sum = (int'(base) + offset) % N_REQ;
        return sum[ID_W-1:0];
    endfunction

    // Round-robin winner search. The loop walks the ring from the farthest
    // position down to the nearest one. The last hit written is therefore the
    // first set bit after ptr.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_i[ring_idx(ptr, i)]) begin
                win_valid = 1'b1;
                win_idx   = ring_idx(ptr, i);
            end
        end
    end

    // Grant decision for this cycle. A clear always suppresses the grant.
    // In ACK no arbitration happens.
    always_comb begin
        grant     = 1'b0;
        grant_idx = win_idx;
        case (state)
            ST_IDLE: grant = win_valid & ~clr_i;
`ifdef IOB_REG_ARB_LOCK_EN
            ST_LOCKED: begin
                grant_idx = owner;
                grant     = ~clr_i & lock_i[owner] & req_i[owner];
            end
`endif
            default: grant = 1'b0;
        endcase
    end

    // Shared register: enabled by a grant or a clear. The clear wins the mux.
    assign reg_en = grant | clr_i;
    assign reg_d  = clr_i ? RST_VAL : slice[grant_idx];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_q <= RST_VAL;
        end else if (cke_i && reg_en) begin
            // NOTE: state is updated with non-blocking assignments only, so
            // every flop samples values from before the edge.
            data_q <= reg_d;
        end
    end

    // Arbitration FSM with registered ack/upd/owner/pointer.
    // The reset pointer of N_REQ-1 makes requester 0 win first.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= ST_IDLE;
            ptr   <= ID_W'(N_REQ - 1);
            owner <= '0;
            ack   <= '0;
            upd   <= 1'b0;
        end else if (cke_i) begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state <= ST_ACK;
                        ptr   <= grant_idx;
                        owner <= grant_idx;
                        ack   <= N_REQ'(1) << grant_idx;
                        upd   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    // The acknowledge always completes, even under a clear.
                    ack <= '0;
                    upd <= 1'b0;
`ifdef IOB_REG_ARB_LOCK_EN
                    state <= lock_i[owner] ? ST_LOCKED : ST_IDLE;
`else
                    state <= ST_IDLE;
`endif
                end
`ifdef IOB_REG_ARB_LOCK_EN
                ST_LOCKED: begin
                    // Only the owner may write. Dropping the lock releases
                    // the register, but no grant is made in that cycle.
                    if (grant) begin
                        state <= ST_ACK;
                        ptr   <= grant_idx;
                        owner <= grant_idx;
                        ack   <= N_REQ'(1) << grant_idx;
                        upd   <= 1'b1;
                    end else if (!clr_i && !lock_i[owner]) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    ack   <= '0;
                    upd   <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o   = ack;
    assign upd_o   = upd;
    assign owner_o = owner;
    assign data_o  = data_q;

endmodule

// File: doc/iob_reg_arb.md
# iob_reg_arb

Round-robin write arbiter for a shared enable/reset register. Up to N_REQ requesters each present a data word and a request. The block grants one requester at a time, loads that word into an internal enabled register, and returns a one-cycle acknowledge. It sits between several control agents and one shared configuration/status register, which is instantiated internally as an enabled, synchronously clearable register.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 21, register width
- RST_VAL, {DATA_W{1'b0}}, value on reset and on clear
- ID_W (localparam), $clog2(N_REQ), width of owner_o

Ports:
- clk_i  input  1  clock
- cke_i  input  1  clock enable; low freezes all state
- arst_n_i  input  1  asynchronous active-low reset
- clr_i  input  1  synchronous clear of the register to RST_VAL
- req_i  input  N_REQ  write request, one bit per requester
- data_i  input  N_REQ*DATA_W  write data; requester k uses bits [k*DATA_W +: DATA_W]
- lock_i  input  N_REQ  grant lock request (present only with IOB_REG_ARB_LOCK_EN)
- ack_o  output  N_REQ  one-cycle write acknowledge, one-hot or zero
- data_o  output  DATA_W  register contents
- owner_o  output  ID_W  index of the last granted requester
- upd_o  output  1  one-cycle pulse: data_o changed by a granted write

## Operation
- Reset (arst_n_i low): state IDLE; data_o=RST_VAL; ack_o=0; upd_o=0; owner_o=0; priority pointer=N_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ACK, and LOCKED (lock build only).
- IDLE:
  - If any req_i bit is set, the winner is the first set bit searching upward, with wrap, from pointer+1.
  - At the edge: the register loads the winner's data_i slice; owner_o and pointer are set to the winner; the FSM moves to ACK.
- ACK:
  - ack_o[owner_o]=1 and upd_o=1; no arbitration takes place.
  - The requester must hold req_i and data_i stable until it sees ack. It drops req_i in the ack cycle or the next one. A request still high in ACK is ignored.
  - Next state is LOCKED if lock_i[owner_o]=1 (lock build only), otherwise IDLE.
- LOCKED:
  - Only owner_o may be granted.
  - If req_i[owner_o]=1 and lock_i[owner_o]=1, the register loads that data and the FSM goes to ACK.
  - If lock_i[owner_o]=0, the FSM returns to IDLE with no grant that cycle.
  - Other requesters wait.
- clr_i:
  - The register loads RST_VAL at the next enabled edge. This takes priority over any load in the same cycle.
  - In IDLE or LOCKED, a cycle with clr_i=1 performs no grant and the FSM stays in its state.
  - In ACK, the acknowledge still completes. upd_o is not pulsed for a clear.
- Register enable = (grant this cycle) OR clr_i. Data mux = clr_i ? RST_VAL : winner slice.

## Timing
- Request sampled at edge N → data_o, owner_o valid after edge N; ack_o and upd_o high for the cycle after edge N, falling at edge N+1.
- Maximum throughput: one write per 2 cycles.
- Fairness: with all requests held, grants rotate 0,1,…,N_REQ-1,0.
- cke_i low: FSM, pointer, register and outputs hold. An ack pulse stretches until the next enabled edge.
- arst_n_i asserted mid-ACK: ack_o drops immediately; data_o=RST_VAL.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- IOB_REG_ARB_LOCK_EN defined:
  - lock_i port exists and the LOCKED state is implemented.
  - An owner can perform back-to-back exclusive write sequences.
- Not defined:
  - No lock_i port and no LOCKED state.
  - ACK always returns to IDLE.

## Test plan
- Reset with RST_VAL=21'h15 → data_o=21'h15, ack_o=0, owner_o=0; release, then req_i=4'b0100 with data2=21'h0ABCD → data_o=21'h0ABCD at the edge, ack_o=4'b0100 for one cycle, upd_o=1, owner_o=2.
- req_i=4'b1111 held, data_k=k+1 → grants in order 0,1,2,3,0 every 2 cycles; data_o sequence 1,2,3,4,1.
- clr_i=1 in the same IDLE cycle as req_i=4'b0001 → data_o=RST_VAL, no ack; grant to 0 on the following cycle.
- cke_i=0 for 3 cycles during ACK → ack_o stays high until cke_i=1 and the next edge, then drops; data_o unchanged.
- Lock build: requester 1 holds lock_i[1]=1 and issues 3 writes while req_i[3]=1 → three consecutive acks to 1; requester 3 is granted only after lock_i[1]=0.
- Assert arst_n_i low asynchronously mid-ACK → ack_o=0 and data_o=RST_VAL before the next clock edge.
